uart_tx_fifo: RTL and testbench

Parametrised UART transmit unit, the next generation of the MiniUart TX path.
- Buffers bytes in a small FIFO.
- Serialises frames with a configurable number of data bits, an optional parity bit and 1 or 2 stop bits.
- Driven by the existing one-cycle-per-bit baud tick (en_tx); sits between the bus-side UART register file and the TxD pin.

---
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmit path: small FIFO feeding a start/data/parity/stop serialiser paced by en_tx.
// Optional macro UART_TX_BREAK_EN adds a brk input that forces txd low and freezes the FSM.
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] d_in,
    input  logic                 load,
    input  logic                 en_tx,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 txd,
    output logic                 ts,
    output logic                 full,
    output logic [FIFO_AW:0]     level,
    output logic                 ovf
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shift;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 par_bit;
    logic                 txd_q;
    logic                 brk_on;
    logic                 tick;
    logic                 push;
    logic                 pop;
    logic                 last_stop;

`ifdef UART_TX_BREAK_EN
    assign brk_on = brk;
`else
    assign brk_on = 1'b0;
`endif

    // A held break swallows ticks, so the FSM and FIFO freeze in place.
    assign tick      = en_tx && !brk_on;
    assign full      = (level == (FIFO_AW + 1)'(DEPTH));
    assign push      = load && !full;
    assign last_stop = (state == STOP) && ((STOP_BITS == 1) || stop_cnt);
    assign pop       = tick && (level != '0) && ((state == IDLE) || last_stop);
    assign head      = mem[rd_ptr];

    assign ts  = (state == IDLE) && (level == '0) && !brk_on;
    assign txd = txd_q && !brk_on;

    // NOTE: storage array has no reset; level and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= d_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            ovf <= load && full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            txd_q    <= 1'b1;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift   <= head;
                        bit_cnt <= '0;
                        par_bit <= (^head) ^ (PARITY == 1);
                        state   <= START;
                        txd_q   <= 1'b0;
                    end
                end
                START: begin
                    state <= DATA;
                    txd_q <= shift[0];
                end
                DATA: begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            state <= PAR;
                            txd_q <= par_bit;
                        end else begin
                            state    <= STOP;
                            stop_cnt <= 1'b0;
                            txd_q    <= 1'b1;
                        end
                    end else begin
                        txd_q <= shift[1];
                    end
                end
                PAR: begin
                    state    <= STOP;
                    stop_cnt <= 1'b0;
                    txd_q    <= 1'b1;
                end
                STOP: begin
                    if (!last_stop) begin
                        stop_cnt <= 1'b1;
                    end else if (pop) begin
                        // Next entry waiting: go straight to its start bit, no idle gap.
                        shift   <= head;
                        bit_cnt <= '0;
                        par_bit <= (^head) ^ (PARITY == 1);
                        state   <= START;
                        txd_q   <= 1'b0;
                    end else begin
                        state <= IDLE;
                        txd_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four parameterisations share clock, reset and baud tick;
// sel picks which instance receives load and is observed.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] d_in;
    logic       load;
    logic       en_tx;
    int         sel;
    int         checks;
    int         errors;

    logic       ld0, ld1, ld2, ld3;
    logic       txd0, txd1, txd2, txd3;
    logic       ts0, ts1, ts2, ts3;
    logic       full0, full1, full2, full3;
    logic       ovf0, ovf1, ovf2, ovf3;
    logic [2:0] level0, level1, level2, level3;
    logic       txd_m, ts_m;

    assign ld0 = load && (sel == 0);
    assign ld1 = load && (sel == 1);
    assign ld2 = load && (sel == 2);
    assign ld3 = load && (sel == 3);

    uart_tx_fifo u_dflt (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .load(ld0), .en_tx(en_tx),
        .txd(txd0), .ts(ts0), .full(full0), .level(level0), .ovf(ovf0)
    );

    uart_tx_fifo #(.PARITY(2)) u_even (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .load(ld1), .en_tx(en_tx),
        .txd(txd1), .ts(ts1), .full(full1), .level(level1), .ovf(ovf1)
    );

    uart_tx_fifo #(.PARITY(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .load(ld2), .en_tx(en_tx),
        .txd(txd2), .ts(ts2), .full(full2), .level(level2), .ovf(ovf2)
    );

    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u_d7 (
        .clk(clk), .rst_n(rst_n), .d_in(d_in[6:0]), .load(ld3), .en_tx(en_tx),
        .txd(txd3), .ts(ts3), .full(full3), .level(level3), .ovf(ovf3)
    );

    always_comb begin
        txd_m = txd0;
        ts_m  = ts0;
        case (sel)
            1: begin txd_m = txd1; ts_m = ts1; end
            2: begin txd_m = txd2; ts_m = ts2; end
            3: begin txd_m = txd3; ts_m = ts3; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    // One baud tick every 16 clocks; returns 1ns after the edge that advances the FSM.
    task automatic tick(input logic with_load);
        repeat (15) @(posedge clk);
        #1;
        en_tx = 1'b1;
        load  = with_load;
        @(posedge clk);
        #1;
        en_tx = 1'b0;
        load  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        d_in = d;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic rx(input int n, output logic [31:0] got);
        got = '0;
        for (int k = 0; k < n; k++) begin
            tick(1'b0);
            got[k] = txd_m;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sel = 0;
        checks++; if (txd0 !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd0); end
        checks++; if (ts0 !== 1'b1) begin errors++; $display("FAIL reset_ts: got %b want 1", ts0); end
        checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full0); end
        checks++; if (level0 !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level0); end
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
        rst_n = 1'b1;
        tick(1'b0);
        checks++; if ({txd0, ts0, level0} !== {1'b1, 1'b1, 3'd0}) begin
            errors++; $display("FAIL idle_tick: got txd=%b ts=%b level=%0d want 1 1 0", txd0, ts0, level0);
        end
    endtask

    task automatic test_basic();
        logic [31:0] got;
        sel = 0;
        push(8'h55);
        checks++; if ({ts_m, txd_m} !== 2'b01) begin
            errors++; $display("FAIL basic_pushed: got ts=%b txd=%b want ts=0 txd=1", ts_m, txd_m);
        end
        rx(10, got);
        checks++; if (got[9:0] !== 10'h2AA) begin errors++; $display("FAIL basic_frame: got %h want 2aa", got[9:0]); end
        checks++; if (ts_m !== 1'b0) begin errors++; $display("FAIL basic_ts_stop: got %b want 0", ts_m); end
        tick(1'b0);
        checks++; if ({ts_m, txd_m} !== 2'b11) begin
            errors++; $display("FAIL basic_done: got ts=%b txd=%b want 1 1", ts_m, txd_m);
        end
    endtask

    task automatic test_parity();
        logic [31:0] got;
        sel = 1;
        push(8'h07);
        rx(11, got);
        checks++; if (got[10:0] !== 11'h60E) begin errors++; $display("FAIL even_frame: got %h want 60e", got[10:0]); end
        tick(1'b0);
        checks++; if (ts_m !== 1'b1) begin errors++; $display("FAIL even_done: got ts=%b want 1", ts_m); end
        sel = 2;
        push(8'h07);
        rx(11, got);
        checks++; if (got[10:0] !== 11'h40E) begin errors++; $display("FAIL odd_frame: got %h want 40e", got[10:0]); end
        tick(1'b0);
        checks++; if (ts_m !== 1'b1) begin errors++; $display("FAIL odd_done: got ts=%b want 1", ts_m); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        sel = 0;
        got = '0;
        push(8'hA5);
        for (int k = 0; k < 20; k++) begin
            tick(1'b0);
            got[k] = txd_m;
            if (k == 2) push(8'h3C);
        end
        checks++; if (got[19:0] !== 20'h9E34A) begin errors++; $display("FAIL b2b_frames: got %h want 9e34a", got[19:0]); end
        tick(1'b0);
        checks++; if (ts_m !== 1'b1) begin errors++; $display("FAIL b2b_done: got ts=%b want 1", ts_m); end
    endtask

    task automatic test_overflow();
        logic [63:0] got;
        logic [9:0]  exp_f [4];
        exp_f = '{10'h222, 10'h244, 10'h266, 10'h288};
        sel = 0;
        got = '0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        checks++; if ({level0, full0, ovf0} !== {3'd4, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ovf_fill: got level=%0d full=%b ovf=%b want 4 1 0", level0, full0, ovf0);
        end
        push(8'h99);
        checks++; if ({level0, ovf0} !== {3'd4, 1'b1}) begin
            errors++; $display("FAIL ovf_drop: got level=%0d ovf=%b want 4 1", level0, ovf0);
        end
        @(posedge clk);
        #1;
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_pulse: got %b want 0", ovf0); end
        // Load while full on the popping tick is still dropped.
        d_in = 8'h99;
        tick(1'b1);
        checks++; if ({level0, full0, ovf0, txd0} !== {3'd3, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ovf_pop_drop: got level=%0d full=%b ovf=%b txd=%b want 3 0 1 0",
                               level0, full0, ovf0, txd0);
        end
        got[0] = txd0;
        for (int k = 1; k < 40; k++) begin
            tick(1'b0);
            got[k] = txd0;
        end
        for (int j = 0; j < 4; j++) begin
            checks++; if (got[j*10 +: 10] !== exp_f[j]) begin
                errors++; $display("FAIL ovf_frame%0d: got %h want %h", j, got[j*10 +: 10], exp_f[j]);
            end
        end
        tick(1'b0);
        checks++; if ({ts0, level0} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL ovf_done: got ts=%b level=%0d want 1 0", ts0, level0);
        end
    endtask

    task automatic test_data7();
        logic [31:0] got;
        sel = 3;
        push(8'h41);
        rx(10, got);
        checks++; if (got[9:0] !== 10'h382) begin errors++; $display("FAIL d7_frame: got %h want 382", got[9:0]); end
        checks++; if (ts_m !== 1'b0) begin errors++; $display("FAIL d7_ts_stop2: got %b want 0", ts_m); end
        tick(1'b0);
        checks++; if (ts_m !== 1'b1) begin errors++; $display("FAIL d7_done: got ts=%b want 1", ts_m); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        sel = 0;
        push(8'h55);
        push(8'h0F);
        for (int k = 0; k < 5; k++) tick(1'b0);
        checks++; if ({txd0, level0} !== {1'b0, 3'd1}) begin
            errors++; $display("FAIL mid_bit3: got txd=%b level=%0d want 0 1", txd0, level0);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({txd0, ts0, level0} !== {1'b1, 1'b1, 3'd0}) begin
            errors++; $display("FAIL mid_reset: got txd=%b ts=%b level=%0d want 1 1 0", txd0, ts0, level0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(8'hC3);
        rx(10, got);
        checks++; if (got[9:0] !== 10'h386) begin errors++; $display("FAIL mid_clean_frame: got %h want 386", got[9:0]); end
        tick(1'b0);
        checks++; if (ts0 !== 1'b1) begin errors++; $display("FAIL mid_done: got ts=%b want 1", ts0); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sel    = 0;
        d_in   = '0;
        load   = 1'b0;
        en_tx  = 1'b0;
        rst_n  = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_overflow();
        test_data7();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
